systolic_drain: RTL and testbench

- Output-side collector for the systolic matrix-multiply array. Consumes the staggered per-column results and active flags from the bottom PE row.
- Deskews the columns into aligned result rows and buffers them in a row FIFO. Presents the rows on a valid/ready stream to the result writer.
- Back-pressures the array through its active input when buffer space runs low. It is the reading end of the PE row's maccout/activeout outputs.

---
 rtl/systolic_drain.sv | 150 +++++++++++++++
 tb/tb_systolic_drain.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_drain.sv
//=============================================================================
// Module   : systolic_drain
// Purpose  : Output-side collector for the systolic matrix-multiply array.
//            Deskews the staggered bottom-row column results into aligned
//            rows, buffers them in a row FIFO and presents them on a
//            valid/ready stream. Back-pressures the array via array_active
//            when free FIFO space drops to STALL_MARGIN rows or fewer.
// Ports    : clock, reset_n (sync, active-low)
//            sum_in/act_in  - bottom-row maccout / activeout (column-packed)
//            array_active   - registered stall control to the array
//            out_data/out_valid/out_ready - aligned row stream
//            level, rows_out, skew_err, overflow - status
// Revision : 1.0 - initial release
//=============================================================================
`default_nettype none

module systolic_drain #(
  parameter int COLS         = 4,
  parameter int SUM_W        = 16,
  parameter int DEPTH        = 8,
  parameter int STALL_MARGIN = 5
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [COLS*SUM_W-1:0]    sum_in,
  input  logic [COLS-1:0]          act_in,
  output logic                     array_active,
  output logic [COLS*SUM_W-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              rows_out,
  output logic                     skew_err,
  output logic                     overflow
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_LW = c_AW + 1;

  // Aligned row at the deskew output
  logic [COLS*SUM_W-1:0] w_al_data;
  logic [COLS-1:0]       w_al_act;

  // Column c is delayed COLS-1-c cycles so all columns of a row meet at once
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int c_D = COLS - 1 - c;
    if (c_D == 0) begin : g_direct
      assign w_al_data[c*SUM_W +: SUM_W] = sum_in[c*SUM_W +: SUM_W];
      assign w_al_act[c]                 = act_in[c];
    end else begin : g_delay
      logic [SUM_W-1:0] r_val [c_D];
      logic [c_D-1:0]   r_act;
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          for (int i = 0; i < c_D; i++) r_val[i] <= '0;
          r_act <= '0;
        end else begin
          r_val[0] <= sum_in[c*SUM_W +: SUM_W];
          r_act[0] <= act_in[c];
          for (int i = 1; i < c_D; i++) begin
            r_val[i] <= r_val[i-1];
            r_act[i] <= r_act[i-1];
          end
        end
      end
      assign w_al_data[c*SUM_W +: SUM_W] = r_val[c_D-1];
      assign w_al_act[c]                 = r_act[c_D-1];
    end
  end

  // FIFO state
  logic [COLS*SUM_W-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]       r_wr;
  logic [c_AW-1:0]       r_rd;
  logic [c_LW-1:0]       r_level;
  logic [COLS*SUM_W-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_active;
  logic [15:0]           r_rows_out;
  logic                  r_skew_err;
  logic                  r_overflow;

  logic                  w_push;
  logic                  w_skew;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push_ok;
  logic                  w_ovf;
  logic [c_LW-1:0]       w_level_nxt;
  logic [c_AW-1:0]       w_rd_nxt;
  logic [COLS*SUM_W-1:0] w_head_nxt;
  logic                  w_active_nxt;

  always_comb begin
    w_push      = &w_al_act;
    w_skew      = (|w_al_act) & ~(&w_al_act);
    w_full      = (r_level == c_LW'(DEPTH));
    w_pop       = r_out_valid & out_ready;
    // When full, a simultaneous pop frees the slot the push needs
    w_push_ok   = w_push & (~w_full | w_pop);
    w_ovf       = w_push & w_full & ~w_pop;
    w_level_nxt = r_level + c_LW'(w_push_ok) - c_LW'(w_pop);
    w_rd_nxt    = w_pop ? r_rd + c_AW'(1) : r_rd;
    // The next head is the row being written this edge when it lands at the
    // next read slot (push into empty, or push+pop at level 1)
    if (w_push_ok && (w_rd_nxt == r_wr)) w_head_nxt = w_al_data;
    else                                 w_head_nxt = r_mem[w_rd_nxt];
    w_active_nxt = (DEPTH - int'(w_level_nxt)) > STALL_MARGIN;
  end

  // Storage has no reset; pointers and level define what is valid
  always_ff @(posedge clock) begin
    if (reset_n && w_push_ok) r_mem[r_wr] <= w_al_data;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wr        <= '0;
      r_rd        <= '0;
      r_level     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_active    <= 1'b0;
      r_rows_out  <= '0;
      r_skew_err  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + c_AW'(1);
      r_rd        <= w_rd_nxt;
      r_level     <= w_level_nxt;
      r_out_valid <= (w_level_nxt != '0);
      if (w_level_nxt != '0) r_out_data <= w_head_nxt;
      r_active    <= w_active_nxt;
      if (w_pop)  r_rows_out <= r_rows_out + 16'd1;
      if (w_skew) r_skew_err <= 1'b1;
      if (w_ovf)  r_overflow <= 1'b1;
    end
  end

  assign array_active = r_active;
  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign level        = r_level;
  assign rows_out     = r_rows_out;
  assign skew_err     = r_skew_err;
  assign overflow     = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_systolic_drain.sv
//=============================================================================
// Module   : tb_systolic_drain
// Purpose  : Directed, table-driven bench for systolic_drain (COLS=4,
//            SUM_W=16, DEPTH=8, STALL_MARGIN=5). Rows are injected staggered
//            from a per-cycle schedule.
// Revision : 1.0 - initial release
//=============================================================================
`default_nettype none

module tb_systolic_drain;

  logic        clock;
  logic        reset_n;
  logic [63:0] sum_in;
  logic [3:0]  act_in;
  logic        array_active;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  level;
  logic [15:0] rows_out;
  logic        skew_err;
  logic        overflow;

  systolic_drain #(.COLS(4), .SUM_W(16), .DEPTH(8), .STALL_MARGIN(5)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .sum_in       (sum_in),
    .act_in       (act_in),
    .array_active (array_active),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .level        (level),
    .rows_out     (rows_out),
    .skew_err     (skew_err),
    .overflow     (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [63:0] in_sum [64];
  logic [3:0]  in_act [64];

  typedef struct {
    logic [63:0] row;
    logic [3:0]  act;
    logic        exp_valid;
    logic        exp_skew;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic clear_sched();
    for (int i = 0; i < 64; i++) begin
      in_sum[i] = '0;
      in_act[i] = '0;
    end
    cyc = 0;
  endtask

  // Column c of a row starting at t0 is presented in cycle t0+c
  task automatic add_row(input int t0, input logic [63:0] row, input logic [3:0] act);
    for (int c = 0; c < 4; c++) begin
      in_sum[t0+c][c*16 +: 16] = row[c*16 +: 16];
      in_act[t0+c][c]          = act[c];
    end
  endtask

  // Drive this cycle's inputs, advance one edge, land 1ns into the next cycle
  task automatic step();
    sum_in = (cyc < 64) ? in_sum[cyc] : 64'd0;
    act_in = (cyc < 64) ? in_act[cyc] : 4'd0;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  function automatic logic [63:0] mkrow(input int k);
    logic [63:0] r;
    for (int c = 0; c < 4; c++) r[c*16 +: 16] = 16'(16'h1000 + k*16 + c);
    return r;
  endfunction

  // Pop n rows in order (out_ready must be 1), expecting mkrow(base+k)
  task automatic drain_check(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      int w = 0;
      while (!out_valid && w < 5) begin
        step();
        w++;
      end
      chk("drain_valid", 64'(out_valid), 64'd1);
      chk("drain_data", out_data, mkrow(base + k));
      step();
    end
  endtask

  initial begin
    int peak;
    logic [63:0] r;

    vecs[0] = '{row: 64'h1234_ABCD_0F0F_8001, act: 4'hF, exp_valid: 1'b1, exp_skew: 1'b0};
    vecs[1] = '{row: 64'hFFFF_8000_7FFF_0000, act: 4'hF, exp_valid: 1'b1, exp_skew: 1'b0};
    vecs[2] = '{row: 64'hDEAD_BEEF_CAFE_F00D, act: 4'h0, exp_valid: 1'b0, exp_skew: 1'b0};
    vecs[3] = '{row: 64'h5555_AAAA_5555_AAAA, act: 4'b1011, exp_valid: 1'b0, exp_skew: 1'b1};

    // ---------------- reset state ----------------
    clear_sched();
    reset_n   = 1'b0;
    out_ready = 1'b0;
    sum_in    = '0;
    act_in    = '0;
    step();
    step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_active", 64'(array_active), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_rows_out", 64'(rows_out), 64'd0);
    chk("rst_flags", {62'd0, skew_err, overflow}, 64'd0);
    reset_n = 1'b1;
    step();
    chk("post_rst_active", 64'(array_active), 64'd1);

    // ---------------- single row, latency ----------------
    clear_sched();
    out_ready = 1'b1;
    add_row(10, {16'd103, 16'd102, 16'd101, 16'd100}, 4'hF);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("single_valid", 64'(out_valid), (cyc == 14) ? 64'd1 : 64'd0);
      if (cyc == 14)
        chk("single_data", out_data, {16'd103, 16'd102, 16'd101, 16'd100});
    end
    chk("single_rows_out", 64'(rows_out), 64'd1);
    chk("single_level", 64'(level), 64'd0);

    // ---------------- table of single-row vectors ----------------
    for (int v = 0; v < 4; v++) begin
      clear_sched();
      out_ready = 1'b1;
      add_row(0, vecs[v].row, vecs[v].act);
      step_to(3);
      chk("vec_early_valid", 64'(out_valid), 64'd0);
      step_to(4);
      chk("vec_valid", 64'(out_valid), 64'(vecs[v].exp_valid));
      if (vecs[v].exp_valid) chk("vec_data", out_data, vecs[v].row);
      chk("vec_skew", 64'(skew_err), 64'(vecs[v].exp_skew));
      step();
      chk("vec_level", 64'(level), 64'd0);
    end
    chk("table_rows_out", 64'(rows_out), 64'd3);

    // good row after a skew error is still delivered; skew_err stays set
    clear_sched();
    add_row(0, 64'h0001_0002_0003_0004, 4'hF);
    step_to(4);
    chk("after_skew_valid", 64'(out_valid), 64'd1);
    chk("after_skew_data", out_data, 64'h0001_0002_0003_0004);
    chk("after_skew_sticky", 64'(skew_err), 64'd1);
    step();
    chk("after_skew_rows_out", 64'(rows_out), 64'd4);

    // ---------------- fill and back-pressure ----------------
    clear_sched();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) add_row(k, mkrow(k), 4'hF);
    peak = 0;
    for (int i = 0; i < 13; i++) begin
      step();
      if (int'(level) > peak) peak = int'(level);
      // free rows = 8 - level; stall while free <= 5
      chk("fill_active", 64'(array_active), (level < 4'd3) ? 64'd1 : 64'd0);
      if (cyc == 6) chk("fill_level_at6", 64'(level), 64'd3);
    end
    chk("fill_peak", 64'(peak), 64'd8);
    chk("fill_overflow", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    drain_check(8, 0);
    chk("fill_drained_level", 64'(level), 64'd0);
    chk("fill_drained_active", 64'(array_active), 64'd1);
    chk("fill_rows_out", 64'(rows_out), 64'd12);

    // ---------------- overflow ----------------
    clear_sched();
    out_ready = 1'b0;
    for (int k = 0; k < 9; k++) add_row(k, mkrow(32 + k), 4'hF);
    step_to(11);
    chk("ovf_not_yet", 64'(overflow), 64'd0);
    step_to(13);
    chk("ovf_level", 64'(level), 64'd8);
    chk("ovf_flag", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    drain_check(8, 32);
    chk("ovf_empty_valid", 64'(out_valid), 64'd0);
    chk("ovf_empty_level", 64'(level), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // ---------------- push and pop at full ----------------
    clear_sched();
    out_ready = 1'b0;
    for (int k = 0; k < 9; k++) add_row(k, mkrow(48 + k), 4'hF);
    step_to(11);
    chk("fullpp_level_pre", 64'(level), 64'd8);
    out_ready = 1'b1;
    step();
    chk("fullpp_level", 64'(level), 64'd8);
    chk("fullpp_head", out_data, mkrow(49));
    drain_check(8, 49);
    chk("fullpp_level_end", 64'(level), 64'd0);

    // ---------------- mid-operation reset ----------------
    clear_sched();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) add_row(k, mkrow(40 + k), 4'hF);
    step_to(8);
    chk("mid_level_pre", 64'(level), 64'd5);
    reset_n = 1'b0;
    step();
    chk("mid_level", 64'(level), 64'd0);
    chk("mid_valid", 64'(out_valid), 64'd0);
    chk("mid_active", 64'(array_active), 64'd0);
    chk("mid_flags", {62'd0, skew_err, overflow}, 64'd0);
    chk("mid_rows_out", 64'(rows_out), 64'd0);
    reset_n = 1'b1;
    step();
    chk("mid_active_after", 64'(array_active), 64'd1);
    for (int i = 0; i < 6; i++) step();
    chk("mid_discard_level", 64'(level), 64'd0);
    chk("mid_discard_valid", 64'(out_valid), 64'd0);
    chk("mid_discard_skew", 64'(skew_err), 64'd0);

    // post-reset row still flows with the nominal latency
    clear_sched();
    r = 64'h8000_7FFF_FFFF_0001;
    add_row(0, r, 4'hF);
    step_to(4);
    chk("post_mid_valid", 64'(out_valid), 64'd1);
    chk("post_mid_data", out_data, r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
